// File: rtl/if_fetch_queue_stage.sv
// if_fetch_queue_stage
//   Instruction-fetch stage. It generates fetch-block PCs and issues
//   FETCH_WIDTH-wide I-cache requests, with at most one request outstanding.
//   Predictor redirection is applied in the same cycle, and slots after a
//   predicted-taken branch are masked. Returned bundles are buffered in a
//   QUEUE_DEPTH-entry fetch queue that hands off to decode with valid/ready.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   init_pc                boot PC, sampled in BOOT
//   redirect_valid/_pc     back-end redirect; flushes the queue
//   pred_*                 predictor result for the current req_addr block
//   req_valid/req_addr     I-cache request strobe and fetch PC
//   resp_valid/resp_instr  I-cache response (latency >= 1)
//   deq_*                  head bundle of the fetch queue, popped on valid&ready
//   queue_count            queue occupancy
module if_fetch_queue_stage #(
    parameter int XLEN        = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int BHSR_W      = 8,
    localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XLEN-1:0]             init_pc,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        pred_taken,
    input  logic [SLOT_W-1:0]           pred_slot,
    input  logic [XLEN-1:0]             pred_target,
    input  logic [BHSR_W-1:0]           pred_bhsr,
    output logic                        req_valid,
    output logic [XLEN-1:0]             req_addr,
    input  logic                        resp_valid,
    input  logic [FETCH_WIDTH*XLEN-1:0] resp_instr,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output logic [XLEN-1:0]             deq_pc,
    output logic [FETCH_WIDTH*XLEN-1:0] deq_instr,
    output logic [FETCH_WIDTH-1:0]      deq_mask,
    output logic [BHSR_W-1:0]           deq_bhsr,
    output logic [XLEN-1:0]             deq_next_pc,
    output logic [CNT_W-1:0]            queue_count
);

    localparam int              PTR_W     = $clog2(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] BLK_BYTES = XLEN'(FETCH_WIDTH * 4);

    typedef enum logic [1:0] {BOOT, IDLE, WAIT, DROP} state_t;

    state_t                r_state, w_next_state;
    logic [XLEN-1:0]       r_fetch_pc;

    // Per-request information, latched at issue and consumed at enqueue
    logic [XLEN-1:0]       r_base, r_target;
    logic [SLOT_W-1:0]     r_start, r_slot;
    logic                  r_taken;
    logic [BHSR_W-1:0]     r_bhsr;

    logic [XLEN-1:0]             r_q_pc     [QUEUE_DEPTH];
    logic [FETCH_WIDTH*XLEN-1:0] r_q_instr  [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0]      r_q_mask   [QUEUE_DEPTH];
    logic [BHSR_W-1:0]           r_q_bhsr   [QUEUE_DEPTH];
    logic [XLEN-1:0]             r_q_next   [QUEUE_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]            r_count;

    logic                   w_issue, w_enq, w_pop;
    logic [XLEN-1:0]        w_base, w_next_pc;
    logic [SLOT_W-1:0]      w_start;
    logic                   w_taken;
    logic [FETCH_WIDTH-1:0] w_mask;

    assign w_base  = r_fetch_pc & ~(BLK_BYTES - XLEN'(1));
    assign w_start = SLOT_W'((r_fetch_pc >> 2) & XLEN'(FETCH_WIDTH - 1));
    // A taken slot before the entry point lies behind the fetch PC, so it is
    // ignored both for the next fetch PC and for the bundle's mask/next_pc.
    assign w_taken = pred_taken && (pred_slot >= w_start);

    // Next-state and request/enqueue decisions
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_enq        = 1'b0;
        case (r_state)
            BOOT: w_next_state = IDLE;
            IDLE: begin
                // Issue uses the pre-pop count; a slot is reserved per request
                if (!redirect_valid && (r_count < CNT_W'(QUEUE_DEPTH))) begin
                    w_issue      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_next_state = resp_valid ? IDLE : DROP;
                end else if (resp_valid) begin
                    w_enq        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DROP: if (resp_valid) w_next_state = IDLE;
            default: w_next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= BOOT;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= '0;
            r_base     <= '0;
            r_target   <= '0;
            r_start    <= '0;
            r_slot     <= '0;
            r_taken    <= 1'b0;
            r_bhsr     <= '0;
        end else if (r_state == BOOT) begin
            r_fetch_pc <= redirect_valid ? redirect_pc : init_pc;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_issue) begin
            r_fetch_pc <= w_taken ? pred_target : w_base + BLK_BYTES;
            r_base     <= w_base;
            r_target   <= pred_target;
            r_start    <= w_start;
            r_slot     <= pred_slot;
            r_taken    <= w_taken;
            r_bhsr     <= pred_bhsr;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            w_mask[i] = (SLOT_W'(i) >= r_start) && (!r_taken || (SLOT_W'(i) <= r_slot));
        end
    end

    assign w_next_pc = r_taken ? r_target : r_base + BLK_BYTES;

    assign deq_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = deq_valid && deq_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) r_q_mask[i] <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_q_mask[r_wr_ptr] <= w_mask;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_wr_ptr]    <= r_base;
            r_q_instr[r_wr_ptr] <= resp_instr;
            r_q_bhsr[r_wr_ptr]  <= r_bhsr;
            r_q_next[r_wr_ptr]  <= w_next_pc;
        end
    end

    assign req_valid   = w_issue;
    assign req_addr    = r_fetch_pc;
    assign deq_pc      = r_q_pc[r_rd_ptr];
    assign deq_instr   = r_q_instr[r_rd_ptr];
    assign deq_mask    = r_q_mask[r_rd_ptr];
    assign deq_bhsr    = r_q_bhsr[r_rd_ptr];
    assign deq_next_pc = r_q_next[r_rd_ptr];
    assign queue_count = r_count;

endmodule

// File: tb/tb_if_fetch_queue_stage.sv
module tb_if_fetch_queue_stage;
    localparam int XLEN = 32;
    localparam int FW   = 2;
    localparam int QD   = 4;
    localparam int BW   = 8;
    localparam logic [31:0] BLK = 32'd8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   init_pc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          pred_taken;
    logic [0:0]    pred_slot;
    logic [31:0]   pred_target;
    logic [7:0]    pred_bhsr;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic [63:0]   resp_instr;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_pc;
    logic [63:0]   deq_instr;
    logic [1:0]    deq_mask;
    logic [7:0]    deq_bhsr;
    logic [31:0]   deq_next_pc;
    logic [2:0]    queue_count;

    if_fetch_queue_stage #(.XLEN(XLEN), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .BHSR_W(BW)) dut (
        .clk(clk), .rst(rst), .init_pc(init_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .pred_bhsr(pred_bhsr), .req_valid(req_valid), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_instr(resp_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
        .deq_instr(deq_instr), .deq_mask(deq_mask), .deq_bhsr(deq_bhsr),
        .deq_next_pc(deq_next_pc), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; redirect_pc = '0;
        pred_taken = 1'b0; pred_slot = '0; pred_target = '0; pred_bhsr = '0;
        resp_valid = 1'b0; resp_instr = '0; deq_ready = 1'b0;
    endtask

    // Leaves the DUT in its first IDLE cycle with fetch PC = ipc
    task automatic do_reset(input logic [31:0] ipc);
        idle_inputs();
        init_pc = ipc;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 128'(req_valid), 128'(0));
        chk("rst_deq_valid", 128'(deq_valid), 128'(0));
        chk("rst_count", 128'(queue_count), 128'(0));
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Table of single-bundle vectors: entry PC + prediction -> expected bundle
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        slot;
        logic [31:0] target;
        logic [31:0] e_deq_pc;
        logic [1:0]  e_mask;
        logic [31:0] e_next;
    } vec_t;
    vec_t tv[6];

    // Reference bundle, computed from the fetch rules at block level
    typedef struct {
        logic [31:0] pc;
        logic [31:0] next;
        logic [1:0]  mask;
        logic [7:0]  bhsr;
        logic [63:0] instr;
    } bundle_t;

    function automatic bundle_t make_bundle(input logic [31:0] pc, input logic taken,
                                            input int slot, input logic [31:0] tgt,
                                            input logic [7:0] bh);
        bundle_t b;
        int start;
        logic eff;
        b.pc   = pc - (pc % BLK);
        start  = int'((pc % BLK) / 4);
        eff    = taken && (slot >= start);
        b.next = eff ? tgt : b.pc + BLK;
        for (int i = 0; i < FW; i++) b.mask[i] = (i >= start) && (!eff || i <= slot);
        b.bhsr  = bh;
        b.instr = '0;
        return b;
    endfunction

    bundle_t     m_q[$];
    bundle_t     pend;
    logic [31:0] m_pc;
    bit          m_out, m_stale;
    int          m_lat;

    initial begin
        logic [63:0] ins;
        int          issues;
        bit          exp_req, exp_dv;
        int          st;

        tv[0] = '{32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0000_1000, 2'b11, 32'h0000_1008};
        tv[1] = '{32'h0000_2004, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_2000, 2'b10, 32'h0000_3000};
        tv[2] = '{32'h0000_2004, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_2000, 2'b10, 32'h0000_2008};
        tv[3] = '{32'h0000_2000, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_2000, 2'b01, 32'h0000_6000};
        tv[4] = '{32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFF8, 2'b11, 32'h0000_0000};
        tv[5] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFF8, 2'b10, 32'h0000_0010};

        // ---- Boot: sequential fetch from init_pc, 1-cycle cache, ID always ready
        do_reset(32'h0000_1000);
        deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k > 0) begin
                chk("boot_deq_valid", 128'(deq_valid), 128'(1));
                chk("boot_deq_pc", 128'(deq_pc), 128'(32'h1000 + 32'(8 * (k - 1))));
                chk("boot_deq_mask", 128'(deq_mask), 128'(2'b11));
                chk("boot_deq_next", 128'(deq_next_pc), 128'(32'h1000 + 32'(8 * k)));
            end
            chk("boot_req_valid", 128'(req_valid), 128'(1));
            chk("boot_req_addr", 128'(req_addr), 128'(32'h1000 + 32'(8 * k)));
            tick();
            resp_valid = 1'b1; resp_instr = {$urandom, $urandom};
            tick();
            resp_valid = 1'b0;
        end

        // ---- Table vectors: each starts in WAIT and redirects together with the response
        do_reset(32'h0000_0100);
        tick();
        for (int v = 0; v < 6; v++) begin
            redirect_valid = 1'b1; redirect_pc = tv[v].pc; resp_valid = 1'b1; deq_ready = 1'b0;
            #1;
            chk("tv_redir_req", 128'(req_valid), 128'(0));
            tick();
            redirect_valid = 1'b0; resp_valid = 1'b0;
            pred_taken = tv[v].taken; pred_slot = tv[v].slot; pred_target = tv[v].target;
            pred_bhsr = 8'(v * 17 + 3);
            #1;
            chk("tv_count_flushed", 128'(queue_count), 128'(0));
            chk("tv_req_valid", 128'(req_valid), 128'(1));
            chk("tv_req_addr", 128'(req_addr), 128'(tv[v].pc));
            tick();
            pred_taken = 1'b0;
            ins = {$urandom, $urandom};
            resp_valid = 1'b1; resp_instr = ins;
            tick();
            resp_valid = 1'b0; deq_ready = 1'b1;
            #1;
            chk("tv_deq_valid", 128'(deq_valid), 128'(1));
            chk("tv_deq_pc", 128'(deq_pc), 128'(tv[v].e_deq_pc));
            chk("tv_deq_mask", 128'(deq_mask), 128'(tv[v].e_mask));
            chk("tv_deq_next", 128'(deq_next_pc), 128'(tv[v].e_next));
            chk("tv_deq_instr", 128'(deq_instr), 128'(ins));
            chk("tv_deq_bhsr", 128'(deq_bhsr), 128'(8'(v * 17 + 3)));
            tick();
        end

        // ---- Backpressure: queue fills to QD, then issue resumes after the first pop
        do_reset(32'h0000_8000);
        issues = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_valid) begin
                chk("bp_req_addr", 128'(req_addr), 128'(32'h8000 + 32'(8 * issues)));
                issues++;
                tick();
                resp_valid = 1'b1; resp_instr = {$urandom, $urandom};
                tick();
                resp_valid = 1'b0;
            end else begin
                tick();
            end
        end
        chk("bp_issues", 128'(issues), 128'(QD));
        chk("bp_count_full", 128'(queue_count), 128'(QD));
        chk("bp_req_held", 128'(req_valid), 128'(0));
        deq_ready = 1'b1;
        #1;
        chk("bp_pop_req", 128'(req_valid), 128'(0));
        chk("bp_pop_pc", 128'(deq_pc), 128'(32'h8000));
        tick();
        deq_ready = 1'b0;
        #1;
        chk("bp_resume_req", 128'(req_valid), 128'(1));
        chk("bp_resume_addr", 128'(req_addr), 128'(32'h8020));
        chk("bp_resume_count", 128'(queue_count), 128'(QD - 1));
        tick();

        // ---- Redirect during a miss: stale response dropped three cycles later
        do_reset(32'h0000_1000);
        #1;
        chk("miss_req_addr", 128'(req_addr), 128'(32'h1000));
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
        #1;
        chk("miss_redir_req", 128'(req_valid), 128'(0));
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            resp_valid = (c == 2);
            #1;
            chk("miss_drop_req", 128'(req_valid), 128'(0));
            tick();
        end
        resp_valid = 1'b0;
        #1;
        chk("miss_count", 128'(queue_count), 128'(0));
        chk("miss_deq_valid", 128'(deq_valid), 128'(0));
        chk("miss_req_valid", 128'(req_valid), 128'(1));
        chk("miss_req_addr2", 128'(req_addr), 128'(32'h4000));
        tick();

        // ---- Redirect coincident with a response while the queue holds a bundle
        do_reset(32'h0000_1000);
        tick();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        #1;
        chk("coin_count1", 128'(queue_count), 128'(1));
        chk("coin_req_addr", 128'(req_addr), 128'(32'h1008));
        tick();
        resp_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
        #1;
        chk("coin_deq_forced", 128'(deq_valid), 128'(0));
        tick();
        resp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("coin_count0", 128'(queue_count), 128'(0));
        chk("coin_req_valid", 128'(req_valid), 128'(1));
        chk("coin_req_addr2", 128'(req_addr), 128'(32'h5000));
        tick();

        // ---- Asynchronous reset in the middle of WAIT
        do_reset(32'h0000_1000);
        tick();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        tick();
        chk("areset_pre_count", 128'(queue_count), 128'(1));
        chk("areset_pre_dv", 128'(deq_valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("areset_req", 128'(req_valid), 128'(0));
        chk("areset_dv", 128'(deq_valid), 128'(0));
        chk("areset_count", 128'(queue_count), 128'(0));
        init_pc = 32'h0000_7000;
        tick();
        rst = 1'b0;
        #1;
        chk("areset_boot_req", 128'(req_valid), 128'(0));
        tick();
        chk("areset_req_valid", 128'(req_valid), 128'(1));
        chk("areset_init_pc", 128'(req_addr), 128'(32'h7000));

        // ---- Randomised run against the transaction-level model
        do_reset({$urandom} & 32'hFFFF_FFFC);
        m_pc = init_pc; m_out = 0; m_stale = 0; m_lat = 0; m_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {$urandom} & 32'hFFFF_FFFC;
            deq_ready      = ((cyc / 200) % 3 == 1) ? ($urandom_range(0, 9) == 0)
                                                     : ($urandom_range(0, 3) != 0);
            resp_valid     = 1'b0;
            if (m_out) begin
                if (m_lat <= 1) resp_valid = 1'b1;
                else            m_lat--;
            end
            resp_instr  = {$urandom, $urandom};
            st          = int'((m_pc % BLK) / 4);
            pred_taken  = ($urandom_range(0, 2) == 0);
            pred_slot   = 1'(st + int'($urandom_range(0, 1 - st)));
            pred_target = {$urandom} & 32'hFFFF_FFFC;
            pred_bhsr   = 8'($urandom);
            #1;
            exp_req = !m_out && (m_q.size() < QD) && !redirect_valid;
            exp_dv  = (m_q.size() != 0) && !redirect_valid;
            chk("rnd_req_valid", 128'(req_valid), 128'(exp_req));
            if (exp_req) chk("rnd_req_addr", 128'(req_addr), 128'(m_pc));
            chk("rnd_deq_valid", 128'(deq_valid), 128'(exp_dv));
            chk("rnd_count", 128'(queue_count), 128'(m_q.size()));
            if (exp_dv) begin
                chk("rnd_deq_pc", 128'(deq_pc), 128'(m_q[0].pc));
                chk("rnd_deq_mask", 128'(deq_mask), 128'(m_q[0].mask));
                chk("rnd_deq_next", 128'(deq_next_pc), 128'(m_q[0].next));
                chk("rnd_deq_instr", 128'(deq_instr), 128'(m_q[0].instr));
                chk("rnd_deq_bhsr", 128'(deq_bhsr), 128'(m_q[0].bhsr));
                if (deq_ready) void'(m_q.pop_front());
            end
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc;
                if (m_out && resp_valid) m_out = 0;
                else if (m_out)          m_stale = 1;
            end else if (exp_req) begin
                pend    = make_bundle(m_pc, pred_taken, int'(pred_slot), pred_target, pred_bhsr);
                m_pc    = pend.next;
                m_out   = 1;
                m_stale = 0;
                m_lat   = int'($urandom_range(1, 3));
            end else if (m_out && resp_valid) begin
                if (!m_stale) begin
                    pend.instr = resp_instr;
                    m_q.push_back(pend);
                end
                m_out = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
